fetch_unit: RTL and testbench

Instruction-fetch controller that sits on the other side of the `pc` register: it computes the next-PC value driven into `pc.d` and consumes `pc.pc` to issue instruction-memory reads. It handles memory wait states, branch/jump redirects and downstream back-pressure. It hands one instruction at a time to decode through a single-entry valid/ready buffer.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and sequential PC step,
// also used by the pc register and the branch unit.
package cpu_pkg;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port plus the single-entry decode handoff.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: next-PC mux, memory request FSM with
// redirect draining, and a one-entry instruction buffer toward decode.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PC_STEP = cpu_pkg::PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  fetch_unit_if.master      bus
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              imem_req_q, imem_req_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [ADDR_W-1:0] target_aligned;
  logic              unused_tgt_bits;

  assign target_aligned  = {redirect_target[ADDR_W-1:2], 2'b00};
  assign unused_tgt_bits = ^redirect_target[1:0];

  always_comb begin
    npc = pc;
    if (redirect) begin
      npc = target_aligned;
    end else if (state_q == REQ && bus.imem_ack) begin
      npc = pc + STEP;
    end
  end

  // Every entry into REQ captures npc, so req_addr always equals pc during REQ.
  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    imem_req_d   = imem_req_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    unique case (state_q)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = npc;
        imem_req_d = 1'b1;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (redirect) begin
            req_addr_d = npc;
          end else begin
            state_d      = HOLD;
            imem_req_d   = 1'b0;
            inst_d       = bus.imem_rdata;
            inst_pc_d    = req_addr_q;
            inst_valid_d = 1'b1;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.imem_ack) begin
          state_d    = REQ;
          req_addr_d = npc;
        end
      end
      HOLD: begin
        if (redirect || bus.inst_ready) begin
          state_d      = REQ;
          req_addr_d   = npc;
          imem_req_d   = 1'b1;
          inst_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = req_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of sequential fetches plus redirect, wrap and
// reset corner sequences; buffered instructions are checked via a scoreboard.
module tb_fetch_unit;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc;
  logic [AW-1:0] npc;
  logic          redirect;
  logic [AW-1:0] tgt;

  fetch_unit_if #(.ADDR_W(AW)) bus ();

  fetch_unit #(.ADDR_W(AW), .PC_STEP(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .npc             (npc),
    .redirect        (redirect),
    .redirect_target (tgt),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  // Model of the pc register: resets to 0, loads npc every edge.
  always_ff @(posedge clk) begin
    if (!rst) pc <= '0;
    else      pc <= npc;
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int unsigned wait_cyc;
    int unsigned hold_cyc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                           input int unsigned wait_cyc, input int unsigned hold_cyc,
                           input bit redir, input logic [31:0] target);
    exp_t        e;
    int unsigned n;
    n = 0;
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    redirect       = 1'b0;
    while (bus.imem_req !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    chk("req_up", 32'(bus.imem_req), 32'd1);
    chk("valid_low_in_req", 32'(bus.inst_valid), 32'd0);
    chk("req_addr", bus.imem_addr, addr);
    chk("pc_at_req", pc, addr);
    for (int unsigned w = 0; w < wait_cyc; w++) begin
      #1;
      chk("npc_wait", npc, addr);
      step();
      chk("req_held", 32'(bus.imem_req), 32'd1);
      chk("addr_held", bus.imem_addr, addr);
      chk("pc_wait", pc, addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    sb.push_back('{inst: rdata, pc: addr});
    #1;
    chk("npc_inc", npc, addr + 32'd4);
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("valid_up", 32'(bus.inst_valid), 32'd1);
    chk("req_down", 32'(bus.imem_req), 32'd0);
    chk("pc_after_ack", pc, addr + 32'd4);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '{inst: 32'h0, pc: 32'h0};
    end else begin
      e = sb.pop_front();
    end
    chk("inst", bus.inst, e.inst);
    chk("inst_pc", bus.inst_pc, e.pc);
    for (int unsigned h = 0; h < hold_cyc; h++) begin
      step();
      chk("hold_valid", 32'(bus.inst_valid), 32'd1);
      chk("hold_inst", bus.inst, e.inst);
      chk("hold_inst_pc", bus.inst_pc, e.pc);
      chk("hold_no_req", 32'(bus.imem_req), 32'd0);
      chk("hold_pc", pc, addr + 32'd4);
    end
    if (redir) begin
      redirect = 1'b1;
      tgt      = target;
      #1;
      chk("npc_redirect", npc, target & ~32'h3);
    end else begin
      bus.inst_ready = 1'b1;
    end
    step();
    redirect       = 1'b0;
    bus.inst_ready = 1'b0;
    chk("valid_drop", 32'(bus.inst_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{addr: 32'h00, rdata: 32'h20080005, wait_cyc: 0, hold_cyc: 0};
    vecs[1] = '{addr: 32'h04, rdata: 32'h11110001, wait_cyc: 1, hold_cyc: 0};
    vecs[2] = '{addr: 32'h08, rdata: 32'h22220002, wait_cyc: 0, hold_cyc: 5};
    vecs[3] = '{addr: 32'h0C, rdata: 32'h33330003, wait_cyc: 2, hold_cyc: 1};
    vecs[4] = '{addr: 32'h10, rdata: 32'h44440004, wait_cyc: 3, hold_cyc: 0};

    redirect       = 1'b0;
    tgt            = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    rst            = 1'b0;
    step();
    step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_npc", npc, 32'h0);
    rst = 1'b1;
    step();

    foreach (vecs[i])
      run_fetch(vecs[i].addr, vecs[i].rdata, vecs[i].wait_cyc, vecs[i].hold_cyc, 1'b0, 32'h0);

    // Redirect while holding an undelivered instruction.
    run_fetch(32'h14, 32'hAAAA0014, 0, 2, 1'b1, 32'h102);

    // Redirect during an unacknowledged request: drain, discard, refetch.
    chk("pre_drain_addr", bus.imem_addr, 32'h100);
    redirect = 1'b1;
    tgt      = 32'h43;
    #1;
    chk("npc_drain_redirect", npc, 32'h40);
    step();
    redirect = 1'b0;
    chk("drain_req", 32'(bus.imem_req), 32'd1);
    chk("drain_addr", bus.imem_addr, 32'h100);
    chk("drain_pc", pc, 32'h40);
    step();
    chk("drain_addr2", bus.imem_addr, 32'h100);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    #1;
    chk("npc_drain_ack", npc, 32'h40);
    step();
    bus.imem_ack = 1'b0;
    chk("post_drain_req", 32'(bus.imem_req), 32'd1);
    chk("post_drain_addr", bus.imem_addr, 32'h40);
    chk("post_drain_valid", 32'(bus.inst_valid), 32'd0);
    chk("post_drain_pc", pc, 32'h40);

    // Redirect coinciding with ack: data dropped, target fetched next.
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBADBAD00;
    redirect       = 1'b1;
    tgt            = 32'h200;
    #1;
    chk("npc_ack_redirect", npc, 32'h200);
    step();
    bus.imem_ack = 1'b0;
    redirect     = 1'b0;
    chk("ackred_req", 32'(bus.imem_req), 32'd1);
    chk("ackred_addr", bus.imem_addr, 32'h200);
    chk("ackred_valid", 32'(bus.inst_valid), 32'd0);
    chk("ackred_pc", pc, 32'h200);

    // Wrap of the PC at the top of the address space.
    run_fetch(32'h200, 32'h00000013, 1, 0, 1'b1, 32'hFFFFFFFF);
    run_fetch(32'hFFFFFFFC, 32'h0000006F, 0, 0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Reset asserted while draining; a late ack must be ignored.
    redirect = 1'b1;
    tgt      = 32'h300;
    step();
    redirect = 1'b0;
    chk("pre_rst_drain_addr", bus.imem_addr, 32'h0);
    chk("pre_rst_drain_pc", pc, 32'h300);
    rst = 1'b0;
    step();
    rst          = 1'b1;
    bus.imem_ack = 1'b1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("mid_rst_inst", bus.inst, 32'h0);
    chk("mid_rst_inst_pc", bus.inst_pc, 32'h0);
    chk("mid_rst_addr", bus.imem_addr, 32'h0);
    #1;
    chk("late_ack_npc", npc, 32'h0);
    step();
    bus.imem_ack = 1'b0;
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    run_fetch(32'h0, 32'h20080005, 0, 0, 1'b0, 32'h0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
